muldiv_unit: RTL and testbench

Parametrised, iterative multiply/divide unit implementing the RV32M operation set. It sits beside the combinational integer ALU in the execute stage. It accepts one operation through a valid/ready handshake, computes it over several cycles, and holds the result until the pipeline takes it. A kill input lets the pipeline abort the operation on a flush.

---
 rtl/muldiv_unit.sv | 152 +++++++++++++++
 tb/tb_muldiv_unit.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// UNROLL result bits per CALC cycle, valid/ready handshake with kill abort.
module muldiv_unit #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned UNROLL = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            kill,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int unsigned N  = XLEN / UNROLL;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [XLEN-1:0] IntMin = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {StIdle, StPrep, StCalc, StFix, StDone} state_e;

  state_e          state_q;
  logic [2:0]      op_q;
  logic [XLEN-1:0] a_q, b_q;
  logic [2*XLEN-1:0] acc_q;
  logic [CW-1:0]   cnt_q;
  logic            neg_q, rneg_q;

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);

  logic is_div, sgn_a, sgn_b, a_neg, b_neg, div_zero, div_ovf;
  assign is_div   = op_q[2];
  assign sgn_a    = (op_q == 3'b001) || (op_q == 3'b010) || (op_q == 3'b100) || (op_q == 3'b110);
  assign sgn_b    = (op_q == 3'b001) || (op_q == 3'b100) || (op_q == 3'b110);
  assign a_neg    = sgn_a & a_q[XLEN-1];
  assign b_neg    = sgn_b & b_q[XLEN-1];
  assign div_zero = is_div && (b_q == '0);
  assign div_ovf  = is_div && !op_q[0] && (a_q == IntMin) && (&b_q);

  // One CALC cycle: acc holds {product hi, product lo} or {remainder, quotient}.
  // Multiply consumes b_q from the LSB; divide consumes a_q from the MSB.
  logic [XLEN-1:0] step_hi, step_lo, step_a, step_b;
  logic [XLEN:0]   tmp, sum;
  always_comb begin
    step_hi = acc_q[2*XLEN-1:XLEN];
    step_lo = acc_q[XLEN-1:0];
    step_a  = a_q;
    step_b  = b_q;
    tmp     = '0;
    sum     = '0;
    for (int unsigned i = 0; i < UNROLL; i++) begin
      if (is_div) begin
        tmp    = {step_hi, step_a[XLEN-1]};
        step_a = step_a << 1;
        if (tmp >= {1'b0, b_q}) begin
          tmp     = tmp - {1'b0, b_q};
          step_lo = {step_lo[XLEN-2:0], 1'b1};
        end else begin
          step_lo = {step_lo[XLEN-2:0], 1'b0};
        end
        step_hi = tmp[XLEN-1:0];
      end else begin
        sum     = {1'b0, step_hi} + (step_b[0] ? {1'b0, a_q} : '0);
        step_lo = {sum[0], step_lo[XLEN-1:1]};
        step_hi = sum[XLEN:1];
        step_b  = step_b >> 1;
      end
    end
  end

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, fix_res;
  always_comb begin
    prod = neg_q  ? -acc_q : acc_q;
    quo  = neg_q  ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem  = rneg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    unique case (op_q)
      3'b000:                 fix_res = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_res = quo;
      default:                fix_res = rem;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      result  <= '0;
    end else if (kill && state_q != StIdle) begin
      state_q <= StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            op_q    <= op;
            a_q     <= a;
            b_q     <= b;
            state_q <= StPrep;
          end
        end
        StPrep: begin
          a_q    <= a_neg ? -a_q : a_q;
          b_q    <= b_neg ? -b_q : b_q;
          neg_q  <= a_neg ^ b_neg;
          rneg_q <= a_neg;
          acc_q  <= '0;
          cnt_q  <= CW'(N - 1);
          // Special cases use the raw operands still held in a_q/b_q this cycle.
          if (div_zero) begin
            result  <= op_q[1] ? a_q : '1;
            state_q <= StDone;
          end else if (div_ovf) begin
            result  <= op_q[1] ? '0 : a_q;
            state_q <= StDone;
          end else begin
            state_q <= StCalc;
          end
        end
        StCalc: begin
          acc_q <= {step_hi, step_lo};
          a_q   <= step_a;
          b_q   <= step_b;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == '0) state_q <= StFix;
        end
        StFix: begin
          result  <= fix_res;
          state_q <= StDone;
        end
        StDone: begin
          if (out_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Drives an UNROLL=1 and an UNROLL=4 unit with identical stimulus and checks both
// against a plain-arithmetic RV32M model, including latency and handshake behaviour.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst, in_valid, kill, out_ready;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        in_ready1, out_valid1, busy1, in_ready4, out_valid4, busy4;
  logic [31:0] result1, result4;
  int          ntests = 0;
  int          nfail  = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32), .UNROLL(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .op(op), .a(a), .b(b),
    .kill(kill), .out_valid(out_valid1), .out_ready(out_ready), .result(result1), .busy(busy1)
  );

  muldiv_unit #(.XLEN(32), .UNROLL(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4), .op(op), .a(a), .b(b),
    .kill(kill), .out_valid(out_valid4), .out_ready(out_ready), .result(result4), .busy(busy4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] x,
                                            input logic [31:0] y);
    logic signed [63:0] sx, sy, uy, p;
    logic [63:0]        u;
    sx = $signed({{32{x[31]}}, x});
    sy = $signed({{32{y[31]}}, y});
    uy = $signed({32'b0, y});
    case (o)
      3'd0: begin p = sx * sy; return p[31:0]; end
      3'd1: begin p = sx * sy; return p[63:32]; end
      3'd2: begin p = sx * uy; return p[63:32]; end
      3'd3: begin u = {32'b0, x} * {32'b0, y}; return u[63:32]; end
      3'd4: begin if (y == 0) return 32'hffff_ffff; p = sx / sy; return p[31:0]; end
      3'd5: begin if (y == 0) return 32'hffff_ffff; return x / y; end
      3'd6: begin if (y == 0) return x; p = sx % sy; return p[31:0]; end
      default: begin if (y == 0) return x; return x % y; end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hffff_ffff;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic check_idle(input string tag);
    check({tag, " out_valid1"}, {31'b0, out_valid1}, 32'd0);
    check({tag, " out_valid4"}, {31'b0, out_valid4}, 32'd0);
    check({tag, " in_ready1"}, {31'b0, in_ready1}, 32'd1);
    check({tag, " in_ready4"}, {31'b0, in_ready4}, 32'd1);
    check({tag, " busy1"}, {31'b0, busy1}, 32'd0);
    check({tag, " busy4"}, {31'b0, busy4}, 32'd0);
  endtask

  task automatic accept(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    in_valid = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    #1;
    // Operands are scrambled after the accept edge; the units must not care.
    in_valid = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input int hold, input string tag);
    logic [31:0] exp, r1, r4;
    int          lat1, lat4, k, elat1, elat4;
    bit          special;
    exp     = ref_model(o, x, y);
    special = o[2] && (y == 0 || (!o[0] && x == 32'h8000_0000 && y == 32'hffff_ffff));
    elat1   = special ? 2 : 35;
    elat4   = special ? 2 : 11;
    r1 = 'x; r4 = 'x; lat1 = 0; lat4 = 0; k = 0;
    out_ready = 1'b0;
    @(negedge clk);
    check({tag, " in_ready1"}, {31'b0, in_ready1}, 32'd1);
    check({tag, " in_ready4"}, {31'b0, in_ready4}, 32'd1);
    accept(o, x, y);
    while ((lat1 == 0 || lat4 == 0) && k < 60) begin
      @(posedge clk);
      #1;
      k++;
      if (lat1 == 0 && out_valid1) begin lat1 = k + 1; r1 = result1; end
      if (lat4 == 0 && out_valid4) begin lat4 = k + 1; r4 = result4; end
    end
    check({tag, " latency1"}, lat1, elat1);
    check({tag, " latency4"}, lat4, elat4);
    check({tag, " result1"}, r1, exp);
    check({tag, " result4"}, r4, exp);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({tag, " hold result1"}, result1, exp);
      check({tag, " hold result4"}, result4, exp);
      check({tag, " hold out_valid1"}, {31'b0, out_valid1}, 32'd1);
      check({tag, " hold in_ready1"}, {31'b0, in_ready1}, 32'd0);
      check({tag, " hold in_ready4"}, {31'b0, in_ready4}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, " post out_valid1"}, {31'b0, out_valid1}, 32'd0);
    check({tag, " post in_ready4"}, {31'b0, in_ready4}, 32'd1);
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    rst = 1'b1; kill = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    check("reset result1", result1, 32'd0);
    check("reset result4", result4, 32'd0);
    rst = 1'b0;

    run_op(3'd0, 32'hffff_ffff, 32'hffff_ffff, 0, "mul");
    run_op(3'd3, 32'hffff_ffff, 32'hffff_ffff, 0, "mulhu");
    run_op(3'd1, 32'h8000_0000, 32'hffff_ffff, 0, "mulh");
    run_op(3'd2, 32'h8000_0000, 32'hffff_ffff, 0, "mulhsu");
    run_op(3'd4, 32'hffff_fff9, 32'd2, 0, "div");
    run_op(3'd6, 32'hffff_fff9, 32'd2, 0, "rem");
    run_op(3'd5, 32'd7, 32'd2, 0, "divu");
    run_op(3'd4, 32'h8000_0000, 32'hffff_ffff, 0, "div ovf");
    run_op(3'd6, 32'h8000_0000, 32'hffff_ffff, 0, "rem ovf");
    run_op(3'd5, 32'd5, 32'd0, 0, "divu zero");
    run_op(3'd7, 32'd5, 32'd0, 0, "remu zero");
    run_op(3'd3, 32'h1234_5678, 32'h9abc_def0, 10, "hold");

    // Kill in the fifth CALC cycle: both units go idle and never present a result.
    accept(3'd0, 32'd12345, 32'd678);
    repeat (5) @(posedge clk);
    #1;
    kill = 1'b1;
    @(posedge clk);
    #1;
    kill = 1'b0;
    check_idle("kill");
    repeat (40) begin
      @(posedge clk);
      #1;
      check("kill no out_valid", {30'b0, out_valid1, out_valid4}, 32'd0);
    end
    run_op(3'd4, 32'hffff_ff00, 32'd7, 0, "after kill");

    // Synchronous reset mid-CALC clears the previously held result too.
    accept(3'd1, 32'hdead_beef, 32'h1234_5678);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_idle("mid rst");
    check("mid rst result1", result1, 32'd0);
    check("mid rst result4", result4, 32'd0);
    run_op(3'd6, 32'd100, 32'hffff_fffd, 0, "after rst");

    for (int n = 0; n < 1000; n++) begin
      ro = 3'($urandom_range(0, 7));
      ra = pick();
      rb = pick();
      run_op(ro, ra, rb, 0, "random");
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
